// File: rtl/amba3_axi_rd_arbiter_pkg.sv
// Shared AMBA3 type definitions for the read-channel arbiter and its
// future write-channel sibling.
package pkg_amba3;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_type_t;

  typedef enum logic [1:0] {
    LOCK_NORMAL = 2'b00,
    LOCK_EXCL   = 2'b01,
    LOCK_LOCKED = 2'b10
  } lock_type_t;

  typedef logic [3:0] cache_attr_t;
  typedef logic [2:0] prot_attr_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_type_t;

  // Arbiter FSM: IDLE picks a winner, GRANT presents it until accepted.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/amba3_axi_rd_arbiter_if.sv
// AXI3 read-channel bundle (AR + R). LANES > 1 packs several masters side by
// side, lane i occupying bits [i*W +: W] of each field.
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high; valid must not depend on ready, and once raised valid and its payload
// hold until the transfer completes.
interface amba3_axi_rd_arbiter_if #(
  parameter int LANES     = 1,
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
);
  logic [LANES*ID_BITS-1:0]   arid;
  logic [LANES*ADDR_BITS-1:0] araddr;
  logic [LANES*4-1:0]         arlen;
  logic [LANES*3-1:0]         arsize;
  logic [LANES*2-1:0]         arburst;
  logic [LANES*2-1:0]         arlock;
  logic [LANES*4-1:0]         arcache;
  logic [LANES*3-1:0]         arprot;
  logic [LANES-1:0]           arvalid;
  logic [LANES-1:0]           arready;
  logic [LANES*ID_BITS-1:0]   rid;
  logic [LANES*DATA_BITS-1:0] rdata;
  logic [LANES*2-1:0]         rresp;
  logic [LANES-1:0]           rlast;
  logic [LANES-1:0]           rvalid;
  logic [LANES-1:0]           rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    output arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    input  arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/amba3_axi_rd_arbiter_rr.sv
// Combinational round-robin picker: first asserted req at or after ptr,
// wrapping modulo N. Shared with the write-channel arbiter.
module amba3_rr_arbiter #(
  parameter int N        = 4,
  parameter int IDX_BITS = $clog2(N)
) (
  input  logic [N-1:0]        req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [IDX_BITS-1:0] idx,
  output logic                any_valid
);

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    idx       = '0;
    any_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx       = IDX_BITS'((int'(ptr) + k) % N);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/amba3_axi_rd_arbiter.sv
// Shares one AXI3 read port between NUM_MST masters. AR requests are
// arbitrated and the slave ID is widened with the master index; R beats are
// routed back by that index. Outstanding bursts per master are capped.
// Build option: AMBA3_AXI_RD_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin.
module amba3_axi_rd_arbiter
  import pkg_amba3::*;
#(
  parameter int NUM_MST   = 4,
  parameter int TXID_BITS = 4,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int MAX_OUTST = 4,
  localparam int MST_BITS = $clog2(NUM_MST),
  localparam int CNT_BITS = $clog2(MAX_OUTST + 1)
) (
  input  logic                         aclk,
  input  logic                         areset,
  amba3_axi_rd_arbiter_if.slave        mst,
  amba3_axi_rd_arbiter_if.master       slv,
  output logic                         route_err,
  output arb_state_t                   dbg_state,
  output logic [MST_BITS-1:0]          dbg_grant,
  output logic [NUM_MST*CNT_BITS-1:0]  dbg_outst
);

  localparam int SID_BITS = TXID_BITS + MST_BITS;

  arb_state_t          state, state_nxt;
  logic [MST_BITS-1:0] grant, grant_nxt, rr_ptr, pick_idx, r_idx;
  logic                pick_any, ar_accept, r_done, r_idx_ok, underflow;
  logic [NUM_MST-1:0]  eligible, inc, dec, zero;
  logic [CNT_BITS-1:0] outst [NUM_MST];

  // A master competes only while it has a request and budget left.
  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      eligible[i] = mst.arvalid[i] && (outst[i] < CNT_BITS'(MAX_OUTST));
      zero[i]     = (outst[i] == '0);
    end
  end

  amba3_rr_arbiter #(.N(NUM_MST), .IDX_BITS(MST_BITS)) u_rr (
    .req       (eligible),
    .ptr       (rr_ptr),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  assign ar_accept = (state == GRANT) && slv.arready;

  // FSM state and grant registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      grant <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  // FSM next state: latch a winner in IDLE, hold it in GRANT until accepted.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_idx;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (slv.arready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef AMBA3_AXI_RD_ARB_FIXED_PRIO_EN
  // Fixed priority: the scan always starts at master 0.
  assign rr_ptr = '0;
`else
  // Round-robin pointer moves just past the master that was accepted.
  always_ff @(posedge aclk) begin
    if (areset) rr_ptr <= '0;
    else if (ar_accept)
      rr_ptr <= (int'(grant) == NUM_MST - 1) ? '0 : grant + 1'b1;
  end
`endif

  // AR mux: present the granted master's fields; only it sees arready.
  always_comb begin
    slv.arvalid     = (state == GRANT);
    slv.arid        = {grant, mst.arid[grant*TXID_BITS +: TXID_BITS]};
    slv.araddr      = mst.araddr[grant*ADDR_BITS +: ADDR_BITS];
    slv.arlen       = mst.arlen[grant*4 +: 4];
    slv.arsize      = mst.arsize[grant*3 +: 3];
    slv.arburst     = mst.arburst[grant*2 +: 2];
    slv.arlock      = mst.arlock[grant*2 +: 2];
    slv.arcache     = mst.arcache[grant*4 +: 4];
    slv.arprot      = mst.arprot[grant*3 +: 3];
    mst.arready     = '0;
    mst.arready[grant] = ar_accept;
  end

  // Upper ID bits name the owning master; an out-of-range index is sunk.
  assign r_idx    = slv.rid[SID_BITS-1:TXID_BITS];
  assign r_idx_ok = ({1'b0, r_idx} < (MST_BITS + 1)'(NUM_MST));

  // R routing: payload broadcast, rvalid one-hot to the owner.
  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      mst.rvalid[i]                            = slv.rvalid && r_idx_ok && (r_idx == MST_BITS'(i));
      mst.rid[i*TXID_BITS +: TXID_BITS]        = slv.rid[TXID_BITS-1:0];
      mst.rdata[i*DATA_BITS +: DATA_BITS]      = slv.rdata;
      mst.rresp[i*2 +: 2]                      = slv.rresp;
      mst.rlast[i]                             = slv.rlast;
    end
    slv.rready = r_idx_ok ? mst.rready[r_idx] : 1'b1;
  end

  assign r_done = slv.rvalid && slv.rready && slv.rlast;

  // Per-master increment on AR accept, decrement on the final R beat.
  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      inc[i] = ar_accept && (grant == MST_BITS'(i));
      dec[i] = r_done && r_idx_ok && (r_idx == MST_BITS'(i));
    end
  end

  assign underflow = |(dec & ~inc & zero);

  // Outstanding counters and the sticky routing error flag.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_MST; i++) outst[i] <= '0;
      route_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_MST; i++) begin
        if (inc[i] && !dec[i])                outst[i] <= outst[i] + 1'b1;
        else if (dec[i] && !inc[i] && !zero[i]) outst[i] <= outst[i] - 1'b1;
      end
      route_err <= route_err | underflow | (slv.rvalid && !r_idx_ok);
    end
  end

  // Debug view of FSM state, current grant and counters.
  always_comb begin
    dbg_state = state;
    dbg_grant = grant;
    for (int i = 0; i < NUM_MST; i++) dbg_outst[i*CNT_BITS +: CNT_BITS] = outst[i];
  end

endmodule

// File: tb/tb_amba3_axi_rd_arbiter.sv
// Bench for amba3_axi_rd_arbiter: a 4-master instance for arbitration,
// routing and counter behaviour, and a 3-master instance for the invalid
// routing index case.
module tb_amba3_axi_rd_arbiter;
  import pkg_amba3::*;

  localparam int NM  = 4;
  localparam int TX  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MO  = 4;
  localparam int MB  = 2;
  localparam int CB  = 3;
  localparam int SID = TX + MB;
  localparam int NM3 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  amba3_axi_rd_arbiter_if #(.LANES(NM),  .ID_BITS(TX),  .ADDR_BITS(AW), .DATA_BITS(DW)) mbus ();
  amba3_axi_rd_arbiter_if #(.LANES(1),   .ID_BITS(SID), .ADDR_BITS(AW), .DATA_BITS(DW)) sbus ();
  amba3_axi_rd_arbiter_if #(.LANES(NM3), .ID_BITS(TX),  .ADDR_BITS(AW), .DATA_BITS(DW)) mbus3 ();
  amba3_axi_rd_arbiter_if #(.LANES(1),   .ID_BITS(SID), .ADDR_BITS(AW), .DATA_BITS(DW)) sbus3 ();

  logic                route_err, route_err3;
  arb_state_t          dbg_state, dbg_state3;
  logic [MB-1:0]       dbg_grant, dbg_grant3;
  logic [NM*CB-1:0]    dbg_outst;
  logic [NM3*CB-1:0]   dbg_outst3;

  amba3_axi_rd_arbiter #(.NUM_MST(NM), .TXID_BITS(TX), .ADDR_BITS(AW), .DATA_BITS(DW), .MAX_OUTST(MO)) u_dut (
    .aclk(clk), .areset(areset), .mst(mbus), .slv(sbus), .route_err(route_err),
    .dbg_state(dbg_state), .dbg_grant(dbg_grant), .dbg_outst(dbg_outst)
  );

  amba3_axi_rd_arbiter #(.NUM_MST(NM3), .TXID_BITS(TX), .ADDR_BITS(AW), .DATA_BITS(DW), .MAX_OUTST(MO)) u_dut3 (
    .aclk(clk), .areset(areset), .mst(mbus3), .slv(sbus3), .route_err(route_err3),
    .dbg_state(dbg_state3), .dbg_grant(dbg_grant3), .dbg_outst(dbg_outst3)
  );

  // ---------------- scoreboard ----------------
  logic [SID+AW+4-1:0] ar_q[$];   // {s_arid, araddr, arlen}
  logic [MB+DW-1:0]    r_q[$];    // {master index, rdata}
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [SID+AW+4-1:0] mk_ar(input logic [MB-1:0] idx, input logic [TX-1:0] id,
                                                input logic [AW-1:0] addr, input logic [3:0] len);
    return {idx, id, addr, len};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    mbus.arid = '0; mbus.araddr = '0; mbus.arlen = '0; mbus.arsize = '0;
    mbus.arburst = '0; mbus.arlock = '0; mbus.arcache = '0; mbus.arprot = '0;
    mbus.arvalid = '0; mbus.rready = '0;
    sbus.arready = '0; sbus.rid = '0; sbus.rdata = '0; sbus.rresp = '0;
    sbus.rlast = '0; sbus.rvalid = '0;
    mbus3.arid = '0; mbus3.araddr = '0; mbus3.arlen = '0; mbus3.arsize = '0;
    mbus3.arburst = '0; mbus3.arlock = '0; mbus3.arcache = '0; mbus3.arprot = '0;
    mbus3.arvalid = '0; mbus3.rready = '0;
    sbus3.arready = '0; sbus3.rid = '0; sbus3.rdata = '0; sbus3.rresp = '0;
    sbus3.rlast = '0; sbus3.rvalid = '0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    areset = 1'b0;
  endtask

  task automatic set_ar(input int i, input logic [TX-1:0] id, input logic [AW-1:0] addr, input logic [3:0] len);
    mbus.arid[i*TX +: TX]   = id;
    mbus.araddr[i*AW +: AW] = addr;
    mbus.arlen[i*4 +: 4]    = len;
    mbus.arsize[i*3 +: 3]   = 3'd2;
    mbus.arburst[i*2 +: 2]  = BURST_INCR;
    mbus.arvalid[i]         = 1'b1;
  endtask

  // Waits (up to budget cycles) for an AR handshake on the slave side and
  // checks it against the head of ar_q. Returns at the negedge after the
  // accepting clock edge.
  task automatic scoreboard_ar(input int budget);
    logic [SID+AW+4-1:0] exp;
    bit seen;
    seen = 1'b0;
    for (int c = 0; c <= budget && !seen; c++) begin
      #1;
      if (sbus.arvalid && sbus.arready) begin
        seen = 1'b1;
        n_tests++;
        if (ar_q.size() == 0) begin
          n_fail++;
          $display("FAIL ar_unexpected: got arid=%h addr=%h with empty queue", sbus.arid, sbus.araddr);
        end else begin
          exp = ar_q.pop_front();
          if ({sbus.arid, sbus.araddr, sbus.arlen} !== exp) begin
            n_fail++;
            $display("FAIL ar_fields: got %h exp %h", {sbus.arid, sbus.araddr, sbus.arlen}, exp);
          end
          n_tests++;
          if (mbus.arready !== 4'(1 << exp[SID+AW+3 -: MB])) begin
            n_fail++;
            $display("FAIL ar_ready_onehot: got %b exp %b", mbus.arready, 4'(1 << exp[SID+AW+3 -: MB]));
          end
        end
      end
      @(negedge clk);
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL ar_timeout: no AR handshake within %0d cycles", budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    areset = 1'b1;
    clear_inputs();
    mbus.arvalid = '1;
    sbus.arready = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (sbus.arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b exp 0", sbus.arvalid); end
    n_tests++;
    if (mbus.arready !== 4'b0) begin n_fail++; $display("FAIL reset_arready: got %b exp 0000", mbus.arready); end
    areset = 1'b0;
    mbus.arvalid = '0;
    sbus.arready = 1'b0;
    n_tests++;
    if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %b exp IDLE", dbg_state); end
    n_tests++;
    if (dbg_outst !== '0 || dbg_grant !== '0) begin
      n_fail++; $display("FAIL reset_counters: outst=%h grant=%0d exp 0", dbg_outst, dbg_grant);
    end
    n_tests++;
    if (route_err !== 1'b0) begin n_fail++; $display("FAIL reset_route_err: got %b exp 0", route_err); end
  endtask

  task automatic test_single();
    logic [DW-1:0] data;
    logic [MB+DW-1:0] exp;
    do_reset();
    set_ar(2, 4'd3, 32'h0000_1000, 4'd3);
    sbus.arready = 1'b1;
    ar_q.push_back(mk_ar(2'd2, 4'd3, 32'h0000_1000, 4'd3));
    scoreboard_ar(1);
    mbus.arvalid[2] = 1'b0;
    sbus.arready = 1'b0;
    n_tests++;
    if (dbg_outst[2*CB +: CB] !== 3'd1) begin n_fail++; $display("FAIL single_outst_inc: got %0d exp 1", dbg_outst[2*CB +: CB]); end
    for (int b = 0; b < 4; b++) begin
      data = $urandom;
      r_q.push_back({2'd2, data});
      sbus.rid = {2'd2, 4'd3}; sbus.rdata = data; sbus.rresp = RESP_OKAY;
      sbus.rlast = (b == 3); sbus.rvalid = 1'b1; mbus.rready = 4'b0100;
      #1;
      exp = r_q.pop_front();
      n_tests++;
      if (mbus.rvalid !== 4'(1 << exp[MB+DW-1 -: MB]) || mbus.rdata[2*DW +: DW] !== exp[DW-1:0] ||
          mbus.rid[2*TX +: TX] !== 4'd3 || sbus.rready !== 1'b1) begin
        n_fail++;
        $display("FAIL single_r_beat%0d: rvalid=%b rid=%h data=%h rready=%b exp rvalid=0100 rid=3 data=%h rready=1",
                 b, mbus.rvalid, mbus.rid[2*TX +: TX], mbus.rdata[2*DW +: DW], sbus.rready, exp[DW-1:0]);
      end
      @(negedge clk);
    end
    sbus.rvalid = 1'b0; sbus.rlast = 1'b0; mbus.rready = '0;
    n_tests++;
    if (dbg_outst[2*CB +: CB] !== 3'd0) begin n_fail++; $display("FAIL single_outst_dec: got %0d exp 0", dbg_outst[2*CB +: CB]); end
  endtask

  task automatic test_rr();
    int order [5];
    logic [NM*CB-1:0] exp_outst;
`ifdef AMBA3_AXI_RD_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 1};
    exp_outst = {3'd0, 3'd0, 3'd1, 3'd4};
`else
    order = '{0, 1, 2, 3, 0};
    exp_outst = {3'd1, 3'd1, 3'd1, 3'd2};
`endif
    do_reset();
    for (int i = 0; i < NM; i++) set_ar(i, TX'(i + 8), AW'(32'h100 * (i + 1)), 4'(i));
    sbus.arready = 1'b1;
    for (int k = 0; k < 5; k++)
      ar_q.push_back(mk_ar(MB'(order[k]), TX'(order[k] + 8), AW'(32'h100 * (order[k] + 1)), 4'(order[k])));
    for (int k = 0; k < 5; k++) scoreboard_ar(3);
    mbus.arvalid = '0;
    sbus.arready = 1'b0;
    n_tests++;
    if (dbg_outst !== exp_outst) begin n_fail++; $display("FAIL rr_outst: got %h exp %h", dbg_outst, exp_outst); end
  endtask

  task automatic test_outst_limit();
    do_reset();
    set_ar(1, 4'd7, 32'h0000_2000, 4'd0);
    sbus.arready = 1'b1;
    for (int k = 0; k < 5; k++) ar_q.push_back(mk_ar(2'd1, 4'd7, 32'h0000_2000, 4'd0));
    for (int k = 0; k < MO; k++) scoreboard_ar(3);
    for (int c = 0; c < 6; c++) begin
      #1;
      n_tests++;
      if (sbus.arvalid !== 1'b0 || mbus.arready[1] !== 1'b0) begin
        n_fail++; $display("FAIL outst_stall_c%0d: arvalid=%b arready1=%b exp 0 0", c, sbus.arvalid, mbus.arready[1]);
      end
      @(negedge clk);
    end
    n_tests++;
    if (dbg_outst[1*CB +: CB] !== 3'd4) begin n_fail++; $display("FAIL outst_full: got %0d exp 4", dbg_outst[1*CB +: CB]); end
    sbus.rid = {2'd1, 4'd7}; sbus.rlast = 1'b1; sbus.rvalid = 1'b1; mbus.rready = 4'b0010;
    @(negedge clk);
    sbus.rvalid = 1'b0; sbus.rlast = 1'b0; mbus.rready = '0;
    scoreboard_ar(4);
    mbus.arvalid = '0;
    sbus.arready = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    set_ar(3, 4'd5, 32'hABCD_0000, 4'd7);
    ar_q.push_back(mk_ar(2'd3, 4'd5, 32'hABCD_0000, 4'd7));
    @(negedge clk);
    set_ar(0, 4'd1, 32'h0000_0040, 4'd0);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_tests++;
      if (sbus.arvalid !== 1'b1 || sbus.arid !== {2'd3, 4'd5} || sbus.araddr !== 32'hABCD_0000 ||
          dbg_grant !== 2'd3 || mbus.arready !== 4'b0) begin
        n_fail++;
        $display("FAIL stall_c%0d: arvalid=%b arid=%h addr=%h grant=%0d arready=%b exp 1 35 abcd0000 3 0000",
                 c, sbus.arvalid, sbus.arid, sbus.araddr, dbg_grant, mbus.arready);
      end
      @(negedge clk);
    end
    sbus.arready = 1'b1;
    scoreboard_ar(0);
    mbus.arvalid[3] = 1'b0;
    ar_q.push_back(mk_ar(2'd0, 4'd1, 32'h0000_0040, 4'd0));
    scoreboard_ar(3);
    mbus.arvalid = '0;
    sbus.arready = 1'b0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_ar(0, 4'd2, 32'h0000_3000, 4'd1);
    sbus.arready = 1'b1;
    for (int k = 0; k < 3; k++) ar_q.push_back(mk_ar(2'd0, 4'd2, 32'h0000_3000, 4'd1));
    scoreboard_ar(3);
    scoreboard_ar(3);
    n_tests++;
    if (dbg_outst[0 +: CB] !== 3'd2) begin n_fail++; $display("FAIL same_pre: got %0d exp 2", dbg_outst[0 +: CB]); end
    @(negedge clk);
    sbus.rid = {2'd0, 4'd2}; sbus.rlast = 1'b1; sbus.rvalid = 1'b1; mbus.rready = 4'b0001;
    scoreboard_ar(0);
    mbus.arvalid = '0; sbus.arready = 1'b0;
    sbus.rvalid = 1'b0; sbus.rlast = 1'b0; mbus.rready = '0;
    n_tests++;
    if (dbg_outst[0 +: CB] !== 3'd2 || route_err !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle: outst0=%0d route_err=%b exp 2 0", dbg_outst[0 +: CB], route_err);
    end
  endtask

  task automatic test_r_routing();
    logic [MB-1:0] idx;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic [3:0]    rdy;
    logic [TX-1:0] lid;
    logic [MB+DW-1:0] exp;
    do_reset();
    for (int b = 0; b < 20; b++) begin
      idx  = MB'($urandom_range(0, NM - 1));
      data = $urandom;
      resp = 2'($urandom_range(0, 3));
      rdy  = 4'($urandom_range(0, 15));
      lid  = TX'($urandom_range(0, 15));
      r_q.push_back({idx, data});
      sbus.rid = {idx, lid}; sbus.rdata = data; sbus.rresp = resp;
      sbus.rlast = 1'b0; sbus.rvalid = 1'b1; mbus.rready = rdy;
      #1;
      exp = r_q.pop_front();
      n_tests++;
      if (mbus.rvalid !== 4'(1 << exp[MB+DW-1 -: MB]) ||
          mbus.rdata[exp[MB+DW-1 -: MB]*DW +: DW] !== exp[DW-1:0] ||
          mbus.rresp[exp[MB+DW-1 -: MB]*2 +: 2] !== resp ||
          mbus.rid[exp[MB+DW-1 -: MB]*TX +: TX] !== lid ||
          sbus.rready !== rdy[exp[MB+DW-1 -: MB]]) begin
        n_fail++;
        $display("FAIL route_beat%0d: rvalid=%b rready=%b exp rvalid=%b rready=%b data exp %h",
                 b, mbus.rvalid, sbus.rready, 4'(1 << exp[MB+DW-1 -: MB]), rdy[exp[MB+DW-1 -: MB]], exp[DW-1:0]);
      end
      @(negedge clk);
    end
    sbus.rvalid = 1'b0; mbus.rready = '0;
    n_tests++;
    if (route_err !== 1'b0) begin n_fail++; $display("FAIL route_no_err: got %b exp 0", route_err); end
  endtask

  task automatic test_underflow();
    do_reset();
    sbus.rid = {2'd2, 4'd0}; sbus.rlast = 1'b1; sbus.rvalid = 1'b1; mbus.rready = 4'b0100;
    #1;
    n_tests++;
    if (mbus.rvalid !== 4'b0100) begin n_fail++; $display("FAIL underflow_route: got %b exp 0100", mbus.rvalid); end
    @(negedge clk);
    sbus.rvalid = 1'b0; sbus.rlast = 1'b0; mbus.rready = '0;
    n_tests++;
    if (route_err !== 1'b1 || dbg_outst[2*CB +: CB] !== 3'd0) begin
      n_fail++; $display("FAIL underflow: route_err=%b outst2=%0d exp 1 0", route_err, dbg_outst[2*CB +: CB]);
    end
  endtask

  task automatic test_invalid_idx();
    sbus3.rid = {2'd3, 4'd1}; sbus3.rlast = 1'b1; sbus3.rvalid = 1'b1; mbus3.rready = '0;
    #1;
    n_tests++;
    if (sbus3.rready !== 1'b1 || mbus3.rvalid !== 3'b000) begin
      n_fail++; $display("FAIL invalid_sink: rready=%b rvalid=%b exp 1 000", sbus3.rready, mbus3.rvalid);
    end
    @(negedge clk);
    sbus3.rvalid = 1'b0; sbus3.rlast = 1'b0;
    n_tests++;
    if (route_err3 !== 1'b1 || dbg_outst3 !== '0) begin
      n_fail++; $display("FAIL invalid_err: route_err=%b outst=%h exp 1 0", route_err3, dbg_outst3);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (route_err3 !== 1'b1) begin n_fail++; $display("FAIL invalid_sticky: got %b exp 1", route_err3); end
  endtask

  // Enters reset with both arbiters mid-GRANT and route_err set on both.
  task automatic test_reset_mid();
    set_ar(1, 4'd4, 32'h0000_5000, 4'd2);
    sbus.arready = 1'b1;
    ar_q.push_back(mk_ar(2'd1, 4'd4, 32'h0000_5000, 4'd2));
    scoreboard_ar(3);
    sbus.arready = 1'b0;
    mbus3.arid[2*TX +: TX] = 4'd6; mbus3.araddr[2*AW +: AW] = 32'h0000_6000; mbus3.arvalid[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (sbus.arvalid !== 1'b1 || sbus3.arvalid !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre: arvalid=%b arvalid3=%b exp 1 1", sbus.arvalid, sbus3.arvalid);
    end
    areset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (sbus.arvalid !== 1'b0 || sbus3.arvalid !== 1'b0 || dbg_state !== IDLE || dbg_state3 !== IDLE) begin
      n_fail++; $display("FAIL midreset_arvalid: arvalid=%b arvalid3=%b exp 0 0", sbus.arvalid, sbus3.arvalid);
    end
    n_tests++;
    if (dbg_outst !== '0 || dbg_outst3 !== '0 || route_err !== 1'b0 || route_err3 !== 1'b0) begin
      n_fail++; $display("FAIL midreset_clear: outst=%h outst3=%h err=%b err3=%b exp all 0",
                         dbg_outst, dbg_outst3, route_err, route_err3);
    end
    clear_inputs();
    areset = 1'b0;
  endtask

  // Hard time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_single();
    test_rr();
    test_outst_limit();
    test_stall();
    test_same_cycle();
    test_r_routing();
    test_underflow();
    test_invalid_idx();
    test_reset_mid();
    n_tests++;
    if (ar_q.size() != 0) begin n_fail++; $display("FAIL ar_queue_left: %0d entries remain, exp 0", ar_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/amba3_axi_rd_arbiter.md
Name: amba3_axi_rd_arbiter

Overview:
- Shares one AMBA3 AXI read port (AR and R channels) between NUM_MST requesting masters.
- Arbitrates AR requests and widens the slave-side ID with the master index.
- Routes R beats back to the owning master by that index.
- Limits outstanding read bursts per master. Sits between master-side amba3_axi_if instances and a single slave-side instance.

Parameters:
- NUM_MST, 4, number of requesting masters (2..8).
- TXID_BITS, 4, master-side ID width.
- ADDR_BITS, 32, address width.
- DATA_BITS, 32, data width.
- MAX_OUTST, 4, maximum outstanding read bursts per master (1..15).
- MST_BITS, $clog2(NUM_MST), derived; slave ID width is TXID_BITS+MST_BITS.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- m_arid  in  NUM_MST*TXID_BITS  per-master AR ID.
- m_araddr  in  NUM_MST*ADDR_BITS  per-master AR address.
- m_arlen  in  NUM_MST*4  burst length-1.
- m_arsize  in  NUM_MST*3  beat size.
- m_arburst  in  NUM_MST*2  burst type.
- m_arlock  in  NUM_MST*2  lock type.
- m_arcache  in  NUM_MST*4  cache attributes.
- m_arprot  in  NUM_MST*3  protection attributes.
- m_arvalid  in  NUM_MST  AR valid.
- m_arready  out  NUM_MST  AR ready.
- m_rid  out  NUM_MST*TXID_BITS  R ID, low TXID_BITS of s_rid.
- m_rdata  out  NUM_MST*DATA_BITS  R data, broadcast.
- m_rresp  out  NUM_MST*2  R response, broadcast.
- m_rlast  out  NUM_MST  R last, broadcast.
- m_rvalid  out  NUM_MST  R valid, one-hot routed.
- m_rready  in  NUM_MST  R ready.
- s_arid  out  TXID_BITS+MST_BITS  {master index, m_arid}.
- s_araddr/s_arlen/s_arsize/s_arburst/s_arlock/s_arcache/s_arprot  out  same widths as the master fields  muxed AR fields.
- s_arvalid  out  1  AR valid.
- s_arready  in  1  AR ready.
- s_rid  in  TXID_BITS+MST_BITS  R ID.
- s_rdata  in  DATA_BITS  R data.
- s_rresp  in  2  R response.
- s_rlast  in  1  R last.
- s_rvalid  in  1  R valid.
- s_rready  out  1  R ready.
- route_err  out  1  sticky: R beat with index >= NUM_MST.

Behaviour:
- Reset (areset=1 at posedge):
  - State IDLE, grant=0, rr_ptr=0, all outst[i]=0, route_err=0.
  - s_arvalid=0, m_arready=0.
  - Any in-flight AR or R is abandoned; a reset mid-burst is legal and leaves no residual state.
- Eligibility: master i is eligible when m_arvalid[i]=1 and outst[i]<MAX_OUTST.
- FSM IDLE:
  - If any master is eligible, select one by round-robin starting at rr_ptr.
  - Register the selection in grant and move to GRANT.
  - Otherwise stay in IDLE.
- FSM GRANT:
  - s_arvalid=1.
  - s_ar* = fields of master grant; s_arid = {grant, m_arid[grant]}.
  - m_arready[grant] = s_arready; all other m_arready = 0.
  - On s_arready=1: outst[grant]++, rr_ptr = (grant+1) mod NUM_MST, return to IDLE.
- AR timing: latency of 1 cycle from m_arvalid to s_arvalid. Throughput is 1 AR per 2 cycles minimum.
- AR protocol: masters must hold m_arvalid and their fields stable until m_arready. The arbiter never deasserts s_arvalid before s_arready.
- R routing (combinational):
  - idx = s_rid[TXID_BITS+MST_BITS-1:TXID_BITS].
  - m_rvalid[idx] = s_rvalid; all other m_rvalid = 0.
  - s_rready = m_rready[idx].
- Invalid R index (idx >= NUM_MST): s_rready=1 so the beat is sunk, no m_rvalid is asserted, route_err is set.
- Counters:
  - outst[idx]-- on s_rvalid & s_rready & s_rlast for a valid idx.
  - Increment and decrement of the same master in one cycle: net unchanged.
  - A decrement at 0 saturates at 0 and sets route_err.
  - Counter width is $clog2(MAX_OUTST+1).
- Cross-channel independence: AR and R channels run independently. An AR for master i can be granted while R beats for master i are in flight.

Optional Feature:
- AMBA3_AXI_RD_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; rr_ptr is not implemented.
- Not defined (default): round-robin as described above.

Decomposition:
- Shared package pkg_amba3 holds:
  - burst_type_t, lock_type_t, cache_attr_t, prot_attr_t, resp_type_t (existing).
  - New: arb_state_t {IDLE, GRANT}.
- Sub-module amba3_rr_arbiter:
  - Combinational round-robin pick: req vector + rr_ptr -> index + any_valid.
  - Reused later by the write-channel arbiter.

Test Plan:
- Single master 2, arid=3, araddr=0x1000, arlen=3 -> s_arid={2,3}, s_araddr=0x1000 one cycle later; 4 R beats with s_rid={2,3} reach only m_rvalid[2], m_rid=3; outst[2] goes 0->1->0 after rlast.
- Masters 0..3 all request continuously with s_arready=1 -> grant order 0,1,2,3,0; with FIXED_PRIO_EN defined -> 0,0,0 (while eligible).
- Master 1 issues 4 ARs (MAX_OUTST=4) with R withheld -> 5th AR stalled and m_arready[1] stays 0; one rlast to master 1 -> 5th AR granted next IDLE cycle.
- s_arready held 0 for 5 cycles in GRANT -> s_arvalid stays 1, fields stable, no other grant; m_arready[grant] pulses in the accept cycle.
- Same-cycle AR accept and rlast for master 0 with outst[0]=2 -> outst[0] remains 2.
- NUM_MST=3, s_rid index=3 -> s_rready=1, no m_rvalid, route_err=1 until areset; areset asserted mid-GRANT -> s_arvalid=0 next cycle, all counters 0.
